// File: rtl/bcd_scan_display.sv
// Time-multiplexed driver for a two-digit BCD count plus an overflow indicator.
// Digit slots are scanned round-robin, with one slot active per prescaler period.
module bcd_scan_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] bcd_in,
  input  logic       co_in,
  input  logic       ack_in,
  input  logic       lzb_en,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [7:0]    snap;
  logic          ovf;
  logic          blink;
  logic [FW-1:0] frame_cnt;

  logic          tick;
  logic          wrap;
  logic [1:0]    idx_next;
  logic [7:0]    snap_next;
  logic          ovf_next;
  logic [6:0]    slot_seg;
  logic [3:0]    slot_an;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  always_comb begin
    tick      = (presc == PRESC_MAX);
    wrap      = tick && (idx == 2'd3);
    idx_next  = idx + 2'd1;
    snap_next = wrap ? bcd_in : snap;
    // Carry/borrow wins over acknowledge so a new event is never dropped.
    if (co_in)       ovf_next = 1'b1;
    else if (ack_in) ovf_next = 1'b0;
    else             ovf_next = ovf;
  end

  // Output pattern for the slot being entered; registered on the same tick.
  always_comb begin
    slot_seg = SEG_BLANK;
    slot_an  = 4'b1111;
    case (idx_next)
      2'd0: begin
        slot_an  = 4'b1110;
        slot_seg = digit_seg(snap_next[3:0]);
      end
      2'd1: begin
        slot_an = 4'b1101;
        if (lzb_en && (snap_next[7:4] == 4'd0)) slot_seg = SEG_BLANK;
        else                                    slot_seg = digit_seg(snap_next[7:4]);
      end
      2'd2: begin
        slot_an  = 4'b1011;
        slot_seg = SEG_BLANK;
      end
      default: begin
        slot_an  = 4'b0111;
        slot_seg = (ovf_next && blink) ? SEG_C : SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc     <= '0;
      idx       <= 2'd0;
      snap      <= 8'h00;
      ovf       <= 1'b0;
      blink     <= 1'b0;
      frame_cnt <= '0;
      an        <= 4'b1110;
      seg       <= 7'b1000000;
    end else begin
      ovf <= ovf_next;
      if (tick) begin
        presc <= '0;
        idx   <= idx_next;
        seg   <= slot_seg;
        an    <= slot_an;
        if (wrap) begin
          snap <= bcd_in;
          if (frame_cnt == FRAME_MAX) begin
            frame_cnt <= '0;
            blink     <= ~blink;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: directed scenarios plus random traffic, each
// cycle's expected an/seg produced by an arithmetic model and queued for a monitor.
module tb_bcd_scan_display;

  localparam int DIV = 4;
  localparam int BF  = 2;

  logic       clk;
  logic       clr;
  logic [7:0] bcd_in;
  logic       co_in;
  logic       ack_in;
  logic       lzb_en;
  logic [6:0] seg;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q[$];

  bcd_scan_display #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .clr(clr), .bcd_in(bcd_in), .co_in(co_in),
    .ack_in(ack_in), .lzb_en(lzb_en), .seg(seg), .an(an)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: everything derives from n, the count of edges since clr released
  logic [6:0]  seg_tab[16];
  int unsigned m_n;
  int unsigned m_idx;
  logic [7:0]  m_snap;
  logic        m_ovf;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
    m_n = 0; m_idx = 0; m_snap = 8'h00; m_ovf = 1'b0;
    e_an = 4'b1110; e_seg = 7'b1000000;
  end

  always @(posedge clk) begin
    int unsigned slot;
    int unsigned frames;
    int unsigned blink;
    if (clr) begin
      m_n = 0; m_snap = 8'h00; m_ovf = 1'b0;
      e_an = 4'b1110; e_seg = 7'b1000000;
    end else begin
      m_n++;
      if (co_in)       m_ovf = 1'b1;
      else if (ack_in) m_ovf = 1'b0;
      if (m_n % DIV == 0) begin
        slot   = (m_n / DIV) % 4;
        frames = m_n / (DIV * 4);
        blink  = (frames / BF) % 2;
        if (slot == 0) m_snap = bcd_in;
        e_an = ~(4'b0001 << slot);
        case (slot)
          0: e_seg = seg_tab[m_snap[3:0]];
          1: e_seg = (lzb_en && m_snap[7:4] == 4'd0) ? 7'b1111111 : seg_tab[m_snap[7:4]];
          2: e_seg = 7'b1111111;
          default: e_seg = (m_ovf && blink == 1) ? 7'b1000110 : 7'b1111111;
        endcase
      end
    end
    m_idx = (m_n / DIV) % 4;
    exp_q.push_back({e_an, e_seg});
  end

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [10:0] exp_v;
    #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL queue_empty t=%0t an=%b seg=%b", $time, an, seg);
    end else begin
      exp_v = exp_q.pop_front();
      if ({an, seg} !== exp_v) begin
        bad++;
        $display("FAIL disp t=%0t n=%0d an=%b seg=%b expected an=%b seg=%b",
                 $time, m_n, an, seg, exp_v[10:7], exp_v[6:0]);
      end
    end
  end

  // driver tasks
  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_co();
    co_in = 1'b1; @(negedge clk); co_in = 1'b0;
  endtask

  task automatic pulse_ack();
    ack_in = 1'b1; @(negedge clk); ack_in = 1'b0;
  endtask

  task automatic wait_idx(input int unsigned k);
    int guard;
    guard = 0;
    while (m_idx != k && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (m_idx != k) begin
      total++;
      bad++;
      $display("FAIL wait_idx timeout idx=%0d wanted=%0d", m_idx, k);
    end
  endtask

  task automatic rand_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      if (i % 48 == 0) bcd_in = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 15) == 0) bcd_in = 8'($urandom_range(0, 255));
      if (i % 64 == 0) lzb_en = 1'($urandom_range(0, 1));
      co_in  = ($urandom_range(0, 59) == 0);
      ack_in = ($urandom_range(0, 39) == 0);
      clr    = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    co_in = 1'b0; ack_in = 1'b0; clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; bcd_in = 8'h00; co_in = 1'b0; ack_in = 1'b0; lzb_en = 1'b0;
    cycles(2);
    // scan and digit decode
    clr = 1'b0; bcd_in = 8'h98;
    cycles(40);
    // change mid-frame, then leading-zero blanking and invalid nibble
    wait_idx(1);
    bcd_in = 8'h03;
    cycles(20);
    lzb_en = 1'b1;
    cycles(32);
    bcd_in = 8'hA5;
    cycles(32);
    bcd_in = 8'h07;
    lzb_en = 1'b0;
    cycles(20);
    // single-cycle overflow pulse, blinking, acknowledge
    wait_idx(2);
    pulse_co();
    cycles(100);
    pulse_ack();
    cycles(40);
    // co_in and ack_in together keep the flag set
    pulse_co();
    co_in = 1'b1; ack_in = 1'b1;
    @(negedge clk);
    co_in = 1'b0; ack_in = 1'b0;
    cycles(80);
    // clr mid-frame at index 2 with overflow set
    wait_idx(2);
    cycles(1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cycles(80);
    // random traffic
    rand_cycles(700);
    cycles(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
